// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply controller: FSM encoding and
// default settle latency of the combinational multiplier array.
package mul_hilo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam int MUL_LAT_DEF = 2;
  localparam int CNT_W       = 4;
  localparam int DATA_W      = 32;

endpackage

// File: rtl/mul_hilo_ctrl_booth.sv
// 32x32 combinational signed multiplier using bit-pair (radix-4 Booth)
// recoding: sixteen partial products of {0, +-a, +-2a} summed into 64 bits.
module mul_hilo_ctrl_booth
  import mul_hilo_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] prod_lo,
  output logic [DATA_W-1:0] prod_hi
);

  logic signed [2*DATA_W-1:0] a_ext;
  logic        [DATA_W:0]     b_ext;
  logic signed [2*DATA_W-1:0] pp;
  logic signed [2*DATA_W-1:0] acc;
  logic        [2:0]          trip;

  assign a_ext = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext = {b, 1'b0};

  always_comb begin
    acc  = '0;
    pp   = '0;
    trip = '0;
    for (int i = 0; i < DATA_W / 2; i++) begin
      trip = b_ext[2*i+2 -: 3];
      // Digit = -2*b[2i+1] + b[2i] + b[2i-1]
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2 * i));
    end
  end

  assign prod_lo = acc[DATA_W-1:0];
  assign prod_hi = acc[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO multiply controller: captures operands, waits MUL_LAT settle cycles
// for the combinational multiplier, then writes the 64-bit product to HI/LO.
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] opa_q, opb_q;
  logic        [CNT_W-1:0]  cnt_q;
  logic        [DATA_W-1:0] hi_q, lo_q;
  logic                     done_q;
  logic        [DATA_W-1:0] prod_lo, prod_hi;

  logic cap_en, cnt_load, cnt_dec, prod_wr, direct_en;

  always_comb begin
    state_d   = state_q;
    cap_en    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    prod_wr   = 1'b0;
    direct_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        direct_en = 1'b1;
        if (start) begin
          cap_en  = 1'b1;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_WRITE;
        else             cnt_dec = 1'b1;
      end
      ST_WRITE: begin
        prod_wr = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture and settle counter
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      opa_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      if (cap_en) begin
        opa_q <= op_a;
        opb_q <= op_b;
      end
      if (cnt_load)     cnt_q <= CNT_LOAD;
      else if (cnt_dec) cnt_q <= cnt_q - 1'b1;
    end
  end

  // HI/LO update; done is registered alongside the product write
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= prod_wr;
      if (prod_wr) begin
        hi_q <= prod_hi;
        lo_q <= prod_lo;
      end else if (direct_en) begin
        if (hi_wr) hi_q <= wr_data;
        if (lo_wr) lo_q <= wr_data;
      end
    end
  end

  mul_hilo_ctrl_booth u_booth (
    .a       (opa_q),
    .b       (opb_q),
    .prod_lo (prod_lo),
    .prod_hi (prod_hi)
  );

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: vector table, randomized products
// against a 64-bit arithmetic model, and hand-written control sequences.
module tb_mul_hilo_ctrl;

  localparam int MUL_LAT = 2;
  localparam int EXP_LAT = MUL_LAT + 2;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        hi_wr, lo_wr;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int n_tests = 0;
  int n_fail  = 0;

  mul_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .hi_wr   (hi_wr),
    .lo_wr   (lo_wr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return 64'(sa * sb);
  endfunction

  // Pulse start with the given operands, then wait (bounded) for done.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    int lat;
    lat = 0;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, ".busy_latch"}, 64'(busy), 64'd1);
    for (int n = 1; n <= 40; n++) begin
      if (scramble) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      @(posedge clock); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (n < EXP_LAT) check({tag, ".busy_wait"}, 64'(busy), 64'd1);
    end
    check({tag, ".latency"}, 64'(lat), 64'(EXP_LAT));
    check({tag, ".hi"}, 64'(hi_out), 64'(ehi));
    check({tag, ".lo"}, 64'(lo_out), 64'(elo));
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
    @(posedge clock); #1;
    check({tag, ".done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] ra, rb, saved_lo;
    int          dones;

    vecs[0] = '{32'd6,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEE};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000};
    vecs[5] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{32'd5,         32'd7,         32'h0000_0000, 32'd35};

    clear = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hi", 64'(hi_out), 64'd0);
    check("reset.lo", 64'(lo_out), 64'd0);

    // First start lands on the first edge after release
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 7; i++)
      do_mul(vecs[i].a, vecs[i].b, 1'b0, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Randomized products against the arithmetic model, with corner operands mixed in
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'h7FFF_FFFF;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      rb = $urandom;
      p = model(ra, rb);
      do_mul(ra, rb, 1'b0, p[63:32], p[31:0], $sformatf("rnd%0d", i));
    end

    // Operands change every cycle while busy
    do_mul(32'd5, 32'd7, 1'b1, 32'd0, 32'd35, "hold");

    // Second start one cycle after the first is dropped
    op_a = 32'd9; op_b = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    op_a = 32'd100; op_b = 32'd100;
    @(posedge clock); #1;
    start = 1'b0;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("busy_start.dones", 64'(dones), 64'd1);
    check("busy_start.hi", 64'(hi_out), 64'd0);
    check("busy_start.lo", 64'(lo_out), 64'd36);

    // Direct writes in IDLE
    hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    hi_wr = 1'b0;
    check("mthi.hi", 64'(hi_out), 64'hDEAD_BEEF);
    check("mthi.lo", 64'(lo_out), 64'd36);
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h1234_5678;
    @(posedge clock); #1;
    hi_wr = 1'b0; lo_wr = 1'b0;
    check("mthilo.hi", 64'(hi_out), 64'h1234_5678);
    check("mthilo.lo", 64'(lo_out), 64'h1234_5678);

    // lo_wr while busy is ignored
    saved_lo = lo_out;
    op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; lo_wr = 1'b1; wr_data = 32'h0000_AAAA;
    @(posedge clock); #1;
    lo_wr = 1'b0;
    check("mtlo_busy.lo", 64'(lo_out), 64'(saved_lo));
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("mtlo_busy.dones", 64'(dones), 64'd1);
    check("mtlo_busy.result", {32'(hi_out), 32'(lo_out)}, 64'd6);

    // Direct write and start on the same edge: write lands, product overwrites it
    hi_wr = 1'b1; wr_data = 32'hCAFE_F00D; op_a = 32'd2; op_b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clock); #1;
    hi_wr = 1'b0; start = 1'b0;
    check("wr_start.hi_direct", 64'(hi_out), 64'hCAFE_F00D);
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("wr_start.dones", 64'(dones), 64'd1);
    check("wr_start.result", {32'(hi_out), 32'(lo_out)}, 64'hFFFF_FFFF_FFFF_FFFE);

    // Clear in WAIT abandons the multiply
    do_mul(32'd3, 32'd5, 1'b0, 32'd0, 32'd15, "pre_clr");
    op_a = 32'd9; op_b = 32'd11; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("clr.in_flight", 64'(busy), 64'd1);
    #2 clear = 1'b0;
    #1;
    check("clr.busy", 64'(busy), 64'd0);
    check("clr.done", 64'(done), 64'd0);
    check("clr.hi", 64'(hi_out), 64'd0);
    check("clr.lo", 64'(lo_out), 64'd0);
    @(negedge clock);
    clear = 1'b1;
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("clr.no_done", 64'(dones), 64'd0);
    check("clr.hilo_kept", {32'(hi_out), 32'(lo_out)}, 64'd0);
    do_mul(32'hFFFF_FFF9, 32'd9, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFC1, "post_clr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
